// File: rtl/fpu_wb_ctl_pkg.sv
// fpu_wb_ctl_pkg
//   Shared definitions for the FPU writeback path: the result FIFO entry
//   layout, field widths and the register-index match helper used by the
//   decode hazard check.
package fpu_wb_ctl_pkg;

    localparam int FPU_FLAGS_W = 5;
    localparam int FPU_REG_W   = 5;
    localparam int FPU_DATA_W  = 32;

    typedef struct packed {
        logic [FPU_REG_W-1:0]  rd;
        logic [FPU_DATA_W-1:0] data;
    } fpu_wb_entry_t;

    // True when register r is any source or the destination of the decode op.
    function automatic logic reg_hit(input logic [FPU_REG_W-1:0] r,
                                     input logic [FPU_REG_W-1:0] rs1,
                                     input logic [FPU_REG_W-1:0] rs2,
                                     input logic [FPU_REG_W-1:0] rs3,
                                     input logic [FPU_REG_W-1:0] rd);
        return (r == rs1) | (r == rs2) | (r == rs3) | (r == rd);
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// fpu_wb_fifo
//   Two-entry synchronous FIFO holding finished FPU results awaiting the
//   shared register-file write port.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     push, push_entry  enqueue one {rd, data} entry
//     pop            dequeue the head entry
//     head           current head entry
//     count          number of valid entries (0..2)
//     entry_valid    per-slot valid bits
//     entry_rd       per-slot destination register, for hazard compares
module fpu_wb_fifo
    import fpu_wb_ctl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  fpu_wb_entry_t                   push_entry,
    input  logic                            pop,
    output fpu_wb_entry_t                   head,
    output logic [1:0]                      count,
    output logic [1:0]                      entry_valid,
    output logic [1:0][FPU_REG_W-1:0]       entry_rd
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    fpu_wb_entry_t mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guards make over/underflow impossible even if the caller misbehaves.
    assign do_push = push & (count != FULL);
    assign do_pop  = pop & (count != 2'd0);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; count and the valid bits decide
    // whether a slot means anything, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            entry_rd[i]    = mem[i].rd;
            entry_valid[i] = (count == FULL) | ((count == 2'd1) & (rd_ptr == 1'(i)));
        end
    end

endmodule

// File: rtl/fpu_wb_ctl.sv
// fpu_wb_ctl
//   Writeback and scoreboard controller for the FPU result path. Tracks the
//   single in-flight FPU destination, buffers finished results, shares the
//   FP register-file write port with loads (loads win), accrues exception
//   flags and reports decode hazards against pending destinations.
//   Ports:
//     issue_valid/issue_rd/issue_ready   op issue handshake into E1
//     fpu_finish/fpu_result/fpu_fflags   result pulse from the FPU
//     flush                              pipeline flush
//     ld_wen/ld_waddr/ld_wdata           FP load writeback request
//     rf_wen/rf_waddr/rf_wdata           FP register-file write port
//     fflags_wen/fflags                  FCSR accrue pulse and flags
//     dec_rs1..3, dec_rd, dec_fp         decode-stage register usage
//     hazard                             decode must stall
//     busy                               op pending or results buffered
module fpu_wb_ctl
    import fpu_wb_ctl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [FPU_REG_W-1:0]   issue_rd,
    output logic                   issue_ready,
    input  logic                   fpu_finish,
    input  logic [FPU_DATA_W-1:0]  fpu_result,
    input  logic [FPU_FLAGS_W-1:0] fpu_fflags,
    input  logic                   flush,
    input  logic                   ld_wen,
    input  logic [FPU_REG_W-1:0]   ld_waddr,
    input  logic [FPU_DATA_W-1:0]  ld_wdata,
    output logic                   rf_wen,
    output logic [FPU_REG_W-1:0]   rf_waddr,
    output logic [FPU_DATA_W-1:0]  rf_wdata,
    output logic                   fflags_wen,
    output logic [FPU_FLAGS_W-1:0] fflags,
    input  logic [FPU_REG_W-1:0]   dec_rs1,
    input  logic [FPU_REG_W-1:0]   dec_rs2,
    input  logic [FPU_REG_W-1:0]   dec_rs3,
    input  logic [FPU_REG_W-1:0]   dec_rd,
    input  logic                   dec_fp,
    output logic                   hazard,
    output logic                   busy
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic                      pend_q;
    logic [FPU_REG_W-1:0]      pend_rd_q;
    logic                      do_issue;
    logic                      do_finish;
    logic                      fifo_pop;
    fpu_wb_entry_t             fifo_head;
    logic [1:0]                fifo_count;
    logic [1:0]                fifo_valid;
    logic [1:0][FPU_REG_W-1:0] fifo_rd;
    logic                      hazard_raw;

    // A pending op blocks issue, so the FIFO can grow by at most one entry
    // per issue and never overflows.
    assign issue_ready = ~pend_q & (fifo_count != FULL);
    assign do_issue    = issue_valid & issue_ready & ~flush;
    assign do_finish   = fpu_finish & pend_q & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_rd_q <= '0;
        end else begin
            if (flush)          pend_q <= 1'b0;
            else if (do_issue)  pend_q <= 1'b1;
            else if (do_finish) pend_q <= 1'b0;
            if (do_issue) pend_rd_q <= issue_rd;
        end
    end

    // Flags are registered so no fpu_* input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_wen <= 1'b0;
            fflags     <= '0;
        end else begin
            fflags_wen <= do_finish;
            if (do_finish) fflags <= fpu_fflags;
        end
    end

    fpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (do_finish),
        .push_entry  ('{rd: pend_rd_q, data: fpu_result}),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .count       (fifo_count),
        .entry_valid (fifo_valid),
        .entry_rd    (fifo_rd)
    );

    // Loads own the port whenever they ask; the FIFO drains otherwise.
    assign fifo_pop = ~ld_wen & (fifo_count != 2'd0);

    // NOTE: every output of this block is assigned on all paths so no latch
    // is inferred.
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (ld_wen) begin
            rf_wen   = 1'b1;
            rf_waddr = ld_waddr;
            rf_wdata = ld_wdata;
        end else if (fifo_count != 2'd0) begin
            rf_wen   = 1'b1;
            rf_waddr = fifo_head.rd;
            rf_wdata = fifo_head.data;
        end
    end

    always_comb begin
        hazard_raw = pend_q & reg_hit(pend_rd_q, dec_rs1, dec_rs2, dec_rs3, dec_rd);
        for (int i = 0; i < 2; i++) begin
            if (fifo_valid[i] & reg_hit(fifo_rd[i], dec_rs1, dec_rs2, dec_rs3, dec_rd))
                hazard_raw = 1'b1;
        end
    end

    assign hazard = dec_fp & hazard_raw;
    assign busy   = pend_q | (fifo_count != 2'd0);

    // Issuing into a busy controller is a protocol error; it is dropped above.
    a_issue_protocol: assert property (@(posedge clk) disable iff (rst)
        issue_valid |-> issue_ready);

    // Issue and finish together would need issue_ready while pending.
    a_no_issue_on_finish: assert property (@(posedge clk) disable iff (rst)
        !(do_issue && do_finish));

endmodule

// File: doc/fpu_wb_ctl.md
# fpu_wb_ctl

Writeback and scoreboard controller for the FPU result path. Consumes the result, finish pulse and status flags from the FPU control stage, and tracks the single in-flight FPU destination register. Buffers finished results in a 2-entry FIFO and writes them to the FP register file through a write port shared with FP loads. Accrues exception flags into FCSR and reports decode-stage hazards against pending destinations.

## Interface
- `DEPTH`, 2: result FIFO entries; fixed at 2, other values unsupported.
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `issue_valid`  in  1  FPU op accepted into E1 this cycle.
- `issue_rd`  in  5  FP destination of the issued op.
- `issue_ready`  out  1  new FPU op may issue.
- `fpu_finish`  in  1  FPU result valid, single-cycle pulse.
- `fpu_result`  in  32  FPU result.
- `fpu_fflags`  in  5  status flags {NV,DZ,OF,UF,NX}.
- `flush`  in  1  pipeline flush (lower).
- `ld_wen`  in  1  FP load writeback request; has priority on the port.
- `ld_waddr`  in  5  FP load destination.
- `ld_wdata`  in  32  FP load data.
- `rf_wen`  out  1  FP register-file write enable.
- `rf_waddr`  out  5  write address.
- `rf_wdata`  out  32  write data.
- `fflags_wen`  out  1  accrue pulse to FCSR.
- `fflags`  out  5  flags to OR into FCSR.fflags.
- `dec_rs1`, `dec_rs2`, `dec_rs3`, `dec_rd`  in  5 each  decode-stage FP register indices.
- `dec_fp`  in  1  the decode instruction uses FP registers.
- `hazard`  out  1  decode must stall.
- `busy`  out  1  op pending or FIFO non-empty.

## Operation
- State: `pend_q` (1 bit), `pend_rd_q` (5 bits), and FIFO entries `{rd[4:0], data[31:0]}` with 1-bit read/write pointers and a 2-bit count.
- Issue: when `issue_valid & issue_ready & ~flush`, set `pend_q` and capture `issue_rd`.
- `issue_ready = ~pend_q & (count != 2)`. This guarantees the FIFO never overflows.
- `issue_valid` while `~issue_ready` is a protocol error. It is ignored, and an assertion fires.
- Finish: when `fpu_finish & pend_q & ~flush`:
  - push `{pend_rd_q, fpu_result}`;
  - clear `pend_q`;
  - register `fflags <= fpu_fflags` and `fflags_wen <= 1`.
- `fpu_finish` with `~pend_q` is ignored: no push, no flags.
- Finish and issue in the same cycle: both take effect. `pend_q` stays 1 and `pend_rd_q` takes the new `issue_rd`. This case only arises if `issue_ready` was already 1, which it is not while pending, so the RTL must still assert its absence.
- Flush:
  - clears `pend_q`;
  - a finish in the same cycle is discarded, including its flags;
  - an issue in the same cycle is dropped;
  - FIFO entries are already retired, so they are kept and still written.
- Port arbitration:
  - `ld_wen=1`: the port carries the `ld_*` values and the FIFO holds.
  - otherwise, if count > 0: the port carries the FIFO head and the entry pops.
  - otherwise: `rf_wen=0`.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- `hazard = dec_fp & (match against pend_rd_q when pend_q | match against each valid FIFO entry rd)`. A match is equality with any of rs1, rs2, rs3 or rd, so WAW is covered.
- `busy = pend_q | (count != 0)`.

## Timing
- Reset values:
  - `pend_q=0`, `pend_rd_q=0`, count=0, pointers=0;
  - `fflags_wen=0`, `fflags=0`;
  - hence `rf_wen=0`, `hazard=0`, `busy=0`, `issue_ready=1`.
- Latency, finish at cycle N with no load contention:
  - FIFO holds the entry at N+1;
  - `rf_wen=1` at N+1;
  - `fflags_wen=1` at N+1 for exactly one cycle.
- Each cycle of `ld_wen` contention delays the FIFO pop by one cycle.
- `rf_w*`, `hazard`, `issue_ready` and `busy` are combinational from registered state plus the `ld_*` and `dec_*` inputs. There is no combinational path from `fpu_*` to any output.
- `rst` asserted mid-operation discards the pending op and all FIFO contents immediately (asynchronous clear).

## Structure
- Shared FPU package gets:
  - typedef `fpu_wb_entry_t` {rd, data};
  - constant `FPU_FLAGS_W=5`.
- One sub-module: `fpu_wb_fifo`, a 2-entry synchronous FIFO with push/pop/count and per-entry rd visibility for the hazard compare.
- The top level holds pending tracking, arbitration and the flags register.

## Test plan
- Reset, then issue rd=5, finish with result 0x3F800000 and fflags 0x01 two cycles later → next cycle `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0x3F800000`, `fflags_wen=1`, `fflags=0x01`, then `busy=0`.
- Pending rd=7 with `dec_rs2=7`, `dec_fp=1` → `hazard=1` until the cycle the FIFO entry for rd 7 is written. With `dec_fp=0` → `hazard=0`.
- Finish with rd=3 while `ld_wen=1` (waddr 9) for 3 cycles → load writes in cycles 1-3, rd 3 is written in cycle 4, and `fflags_wen` still pulses one cycle after the finish.
- Issue rd=4, then `flush` asserted in the same cycle as `fpu_finish` → no FIFO push, `fflags_wen` stays 0, `pend_q=0`, `issue_ready=1`.
- Hold `ld_wen=1` continuously, then complete two ops (rd 1, rd 2) → count=2 and `issue_ready=0`. Release `ld_wen` → rd 1 is written, then rd 2, in consecutive cycles, and `issue_ready` returns to 1.
- Assert `rst` while an op is pending and the FIFO holds 1 entry → all outputs return to their reset values with no clock edge, and no write occurs afterwards.
